// File: rtl/cpu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_seq
//   Multi-cycle control sequencer for the 8-bit CPU datapath. Steps every
//   instruction through FETCH / DECODE / EXEC / WB and produces the IR,
//   register-file and PC write enables. It also handles conditional branch
//   (BZ, opcode 6), halt (opcode 7) and a saturating retired-instruction
//   counter.
//
//   Optional feature macro: CPU_CTRL_STEP_EN
//     Defined   -> step_mode / step_req / step_ack implement a single-step
//                  handshake. Each instruction waits in IDLE for step_req.
//     Undefined -> step_mode and step_req are ignored and step_ack is 0.
//
// Ports
//   CLK        in   1      clock, rising edge
//   RST        in   1      asynchronous active-high reset
//   run        in   1      high allows execution, low parks the sequencer
//   inst       in   8      ROM output; opcode = inst[7:5], target = inst[4:0]
//   alu_zero   in   1      ALU zero output, latched in EXEC of ALU ops
//   step_mode  in   1      selects single-step operation
//   step_req   in   1      level request to run one instruction
//   ir_we      out  1      latch inst into the instruction register
//   reg_we     out  1      register-file write enable
//   pc_we      out  1      PC write enable
//   pc_sel     out  1      0: PC+1, 1: {3'b000, target}
//   target     out  5      branch target captured at DECODE
//   state      out  3      current state code
//   halted     out  1      high while in HALT
//   step_ack   out  1      one-cycle pulse after a retire in step mode
//   retired    out  CNT_W  saturating retired-instruction count
// -----------------------------------------------------------------------------
module cpu_ctrl_seq #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  input  logic [7:0]       inst,
  input  logic             alu_zero,
  input  logic             step_mode,
  input  logic             step_req,
  output logic             ir_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic [4:0]       target,
  output logic [2:0]       state,
  output logic             halted,
  output logic             step_ack,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } stateT;

  localparam logic [2:0] OP_BZ   = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  stateT            state_q, state_d;
  logic [4:0]       target_q;
  logic [2:0]       opcode_q;
  logic             zeroFlag_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  logic             stepActive;
  logic             isBz;
  stateT            afterRetire;

  // Step mode only exists when the feature is compiled in; otherwise the
  // sequencer behaves as if step_mode were permanently low.
`ifdef CPU_CTRL_STEP_EN
  assign stepActive = step_mode;
`else
  logic unusedStepMode;
  assign unusedStepMode = step_mode;
  assign stepActive     = 1'b0;
`endif

  assign isBz = (opcode_q == OP_BZ);

  // After an instruction retires, run is sampled and step mode decides
  // whether we go straight into the next FETCH or park in IDLE.
  assign afterRetire = (stepActive || !run) ? IDLE : FETCH;

  // State register. Reset aborts any in-flight instruction at once, and
  // because every enable is a pure decode of state, all writes drop with it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Run is only looked at in IDLE, HALT and on the retire
  // edge, so an instruction that has started always finishes. Unused codes
  // 6 and 7 fall back to IDLE.
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (run && (!stepActive || step_req)) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = DECODE;
      end
      DECODE: begin
        state_d = (inst[7:5] == OP_HALT) ? HALT : EXEC;
      end
      EXEC: begin
        if (isBz) begin
          retire  = 1'b1;
          state_d = afterRetire;
        end else begin
          state_d = WB;
        end
      end
      WB: begin
        retire  = 1'b1;
        state_d = afterRetire;
      end
      HALT: begin
        if (!run) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore output decode. The only non-state term is pc_sel in a BZ EXEC,
  // which reads the registered zero flag left by earlier instructions.
  always_comb begin
    ir_we  = 1'b0;
    reg_we = 1'b0;
    pc_we  = 1'b0;
    pc_sel = 1'b0;
    halted = 1'b0;
    case (state_q)
      FETCH: begin
        ir_we = 1'b1;
      end
      EXEC: begin
        if (isBz) begin
          pc_we  = 1'b1;
          pc_sel = zeroFlag_q;
        end
      end
      WB: begin
        reg_we = 1'b1;
        pc_we  = 1'b1;
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        ir_we = 1'b0;
      end
    endcase
  end

  // Decode-time capture of the branch target and opcode, the ALU zero flag
  // latched in EXEC of ALU ops, and the saturating retire counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      target_q   <= 5'd0;
      opcode_q   <= 3'd0;
      zeroFlag_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      if (state_q == DECODE) begin
        target_q <= inst[4:0];
        opcode_q <= inst[7:5];
      end
      if ((state_q == EXEC) && !isBz) begin
        zeroFlag_q <= alu_zero;
      end
      if (retire && (retired_q != {CNT_W{1'b1}})) begin
        retired_q <= retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

`ifdef CPU_CTRL_STEP_EN
  logic stepAck_q;

  // step_ack is high for the one cycle after a step-mode retire, which is
  // the first cycle spent back in IDLE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stepAck_q <= 1'b0;
    end else begin
      stepAck_q <= retire && stepActive;
    end
  end

  assign step_ack = stepAck_q;
`else
  assign step_ack = 1'b0;
`endif

  assign state   = state_q;
  assign target  = target_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_ctrl_seq
//   Self-checking bench for cpu_ctrl_seq. An instruction-level model tracks
//   which cycle of which instruction is executing and derives the expected
//   outputs from it. A second instance with a 3-bit counter exercises
//   saturation in a reasonable number of cycles.
// -----------------------------------------------------------------------------
module tb_cpu_ctrl_seq;

`ifdef CPU_CTRL_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic        run;
  logic [7:0]  inst;
  logic        alu_zero;
  logic        step_mode;
  logic        step_req;
  logic        ir_we, reg_we, pc_we, pc_sel, halted, step_ack;
  logic [4:0]  target;
  logic [2:0]  state;
  logic [15:0] retired;
  logic        irWeS, regWeS, pcWeS, pcSelS, haltedS, stepAckS;
  logic [4:0]  targetS;
  logic [2:0]  stateS;
  logic [2:0]  retiredS;

  int testsRun    = 0;
  int testsFailed = 0;

  cpu_ctrl_seq #(.CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .run(run), .inst(inst), .alu_zero(alu_zero),
    .step_mode(step_mode), .step_req(step_req),
    .ir_we(ir_we), .reg_we(reg_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .target(target), .state(state), .halted(halted), .step_ack(step_ack),
    .retired(retired)
  );

  cpu_ctrl_seq #(.CNT_W(3)) dutSmall (
    .CLK(CLK), .RST(RST), .run(run), .inst(inst), .alu_zero(alu_zero),
    .step_mode(step_mode), .step_req(step_req),
    .ir_we(irWeS), .reg_we(regWeS), .pc_we(pcWeS), .pc_sel(pcSelS),
    .target(targetS), .state(stateS), .halted(haltedS), .step_ack(stepAckS),
    .retired(retiredS)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 CLK = ~CLK;

  // Instruction-level model: busy/halt flags, the 1-based cycle number within
  // the current instruction, decoded opcode/target, zero flag, retire count.
  bit          mHalt, mBusy, mZero, mAck;
  int          mK;
  logic [2:0]  mOp;
  logic [4:0]  mTgt;
  int unsigned mCnt;

  task automatic modelReset();
    mHalt = 1'b0; mBusy = 1'b0; mZero = 1'b0; mAck = 1'b0;
    mK = 0; mOp = 3'd0; mTgt = 5'd0; mCnt = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at the edge.
  // A BZ takes 3 cycles, an ALU op 4, HALT leaves after its DECODE cycle.
  task automatic modelStep();
    bit stepOn;
    bit retireNow;
    int len;
    stepOn    = STEP_EN && step_mode;
    retireNow = 1'b0;
    mAck      = 1'b0;
    if (mHalt) begin
      if (!run) mHalt = 1'b0;
    end else if (!mBusy) begin
      if (run && (!stepOn || step_req)) begin
        mBusy = 1'b1;
        mK    = 1;
      end
    end else if (mK == 1) begin
      mK = 2;
    end else if (mK == 2) begin
      mTgt = inst[4:0];
      mOp  = inst[7:5];
      if (mOp == 3'd7) begin
        mBusy = 1'b0;
        mHalt = 1'b1;
      end else begin
        mK = 3;
      end
    end else begin
      len = (mOp == 3'd6) ? 3 : 4;
      if (mK == len) begin
        retireNow = 1'b1;
      end else begin
        mZero = alu_zero;
        mK    = mK + 1;
      end
    end
    if (retireNow) begin
      mCnt = mCnt + 1;
      mAck = stepOn;
      if (stepOn || !run) mBusy = 1'b0;
      else                mK    = 1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against what the model says this cycle holds.
  task automatic checkOutput();
    logic [2:0] expState;
    bit         exec, bz;
    expState = mHalt ? 3'd5 : (mBusy ? 3'(mK) : 3'd0);
    exec     = mBusy && (mK == 3);
    bz       = (mOp == 3'd6);
    check("state",    state,    expState);
    check("ir_we",    ir_we,    mBusy && (mK == 1));
    check("reg_we",   reg_we,   mBusy && (mK == 4));
    check("pc_we",    pc_we,    (mBusy && (mK == 4)) || (exec && bz));
    check("pc_sel",   pc_sel,   exec && bz && mZero);
    check("target",   target,   mTgt);
    check("halted",   halted,   mHalt);
    check("step_ack", step_ack, mAck);
    check("retired",  retired,  (mCnt > 32'd65535) ? 32'd65535 : mCnt);
    check("retired_small", retiredS, (mCnt > 32'd7) ? 32'd7 : mCnt);
    check("state_small",   stateS,   expState);
  endtask

  // Drive one cycle of inputs, let the edge happen, then check 1 ns later.
  task automatic applyStimulus(input bit r, input logic [7:0] i, input bit az,
                               input bit sm, input bit sr);
    run = r; inst = i; alu_zero = az; step_mode = sm; step_req = sr;
    @(posedge CLK);
    #1;
    modelStep();
    checkOutput();
  endtask

  // Asynchronous reset pulse away from the clock edge; outputs must clear
  // immediately, before any further edge.
  task automatic pulseReset();
    RST = 1'b1;
    #1;
    modelReset();
    checkOutput();
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1; run = 1'b0; inst = 8'h00; alu_zero = 1'b0;
    step_mode = 1'b0; step_req = 1'b0;
    modelReset();
    #12;
    check("rst_state",   state,   3'd0);
    check("rst_target",  target,  5'd0);
    check("rst_retired", retired, 16'd0);
    check("rst_enables", {ir_we, reg_we, pc_we, pc_sel, halted, step_ack}, 6'd0);
    checkOutput();
    RST = 1'b0;

    // ALU op 0x25 with alu_zero=1: FETCH, DECODE, EXEC, WB.
    applyStimulus(1, 8'h25, 1, 0, 0);
    check("lit_c1_state", state, 3'd1);
    check("lit_c1_ir_we", ir_we, 1'b1);
    applyStimulus(1, 8'h25, 1, 0, 0);
    applyStimulus(1, 8'h25, 1, 0, 0);
    applyStimulus(1, 8'h25, 1, 0, 0);
    check("lit_c4_we",  {reg_we, pc_we, pc_sel}, 3'b110);
    // BZ 0xD4, zero flag set by the previous ALU op.
    applyStimulus(1, 8'hD4, 0, 0, 0);
    check("lit_c5_state",   state,   3'd1);
    check("lit_c5_retired", retired, 16'd1);
    applyStimulus(1, 8'hD4, 0, 0, 0);
    applyStimulus(1, 8'hD4, 0, 0, 0);
    check("lit_bz_taken", {pc_we, pc_sel}, 2'b11);
    check("lit_bz_target", target, 5'h14);
    // ALU op with alu_zero=0, then BZ not taken.
    for (int c = 0; c < 4; c++) applyStimulus(1, 8'h25, 0, 0, 0);
    check("lit_c8_retired", retired, 16'd2);
    for (int c = 0; c < 3; c++) applyStimulus(1, 8'hD4, 1, 0, 0);
    check("lit_bz_not_taken", {pc_we, pc_sel}, 2'b10);
    // HALT: halted two cycles after FETCH, run=0 releases to IDLE.
    applyStimulus(1, 8'hE0, 0, 0, 0);
    check("lit_halt_fetch", state, 3'd1);
    applyStimulus(1, 8'hE0, 0, 0, 0);
    applyStimulus(1, 8'hE0, 0, 0, 0);
    check("lit_halted", {halted, ir_we, reg_we, pc_we}, 4'b1000);
    check("lit_halt_retired", retired, 16'd4);
    applyStimulus(1, 8'hE0, 0, 0, 0);
    applyStimulus(0, 8'hE0, 0, 0, 0);
    check("lit_halt_exit", state, 3'd0);

    // Reset in the middle of EXEC of an ALU op, just before its WB.
    for (int c = 0; c < 3; c++) applyStimulus(1, 8'h41, 1, 0, 0);
    check("lit_pre_rst_exec", state, 3'd3);
    pulseReset();
    check("lit_midrst", {state, reg_we, pc_we, retired}, 21'd0);
    for (int c = 0; c < 3; c++) applyStimulus(0, 8'h41, 1, 0, 0);

    // Nine ALU ops back to back: the 3-bit counter sticks at 7.
    for (int c = 0; c < 36; c++) applyStimulus(1, 8'h2A, c[0], 0, 0);
    applyStimulus(0, 8'h2A, 0, 0, 0);
    check("lit_sat_small", retiredS, 3'd7);
    check("lit_sat_big",   retired,  16'd9);
    pulseReset();

`ifdef CPU_CTRL_STEP_EN
    // One step_req pulse executes exactly one instruction.
    applyStimulus(1, 8'h25, 0, 1, 0);
    applyStimulus(1, 8'h25, 0, 1, 0);
    check("lit_step_wait", state, 3'd0);
    applyStimulus(1, 8'h25, 0, 1, 1);
    for (int c = 0; c < 4; c++) applyStimulus(1, 8'h25, 0, 1, 0);
    check("lit_step_ack", {step_ack, state}, 4'b1000);
    check("lit_step_retired", retired, 16'd1);
    applyStimulus(1, 8'h25, 0, 1, 0);
    check("lit_step_ack_drop", {step_ack, state}, 4'b0000);
`endif

    // Randomised traffic with occasional asynchronous resets.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        pulseReset();
      end
      applyStimulus($urandom_range(0, 9) != 0, 8'($urandom), 1'($urandom),
                    1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl_seq.md
# cpu_ctrl_seq

Multi-cycle control sequencer for the 8-bit single-cycle CPU datapath (PC register, 8x8 instruction ROM, 8x8 register file, 8-bit ALU). It steps each instruction through FETCH/DECODE/EXEC/WB. It generates the PC, IR, register-file and flag write enables, and adds conditional branch and halt. It also counts retired instructions and optionally supports a debug single-step handshake. It sits between the ROM output and the datapath enables, replacing the tied-high PC and register-file write enables.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- run  in  1  level; high allows execution, low parks the sequencer
- inst  in  8  ROM output for current PC; opcode = inst[7:5], branch target = inst[4:0]
- alu_zero  in  1  ALU zero output for the current operands
- step_mode  in  1  high selects single-step (used only with CPU_CTRL_STEP_EN)
- step_req  in  1  level request to execute one instruction (step mode only)
- ir_we  out  1  latch inst into instruction register
- reg_we  out  1  register-file write enable
- pc_we  out  1  PC register write enable
- pc_sel  out  1  0: PC+1; 1: {3'b000, target}
- target  out  5  branch target captured at DECODE
- state  out  3  current state encoding
- halted  out  1  high while in HALT
- step_ack  out  1  one-cycle pulse on instruction retire in step mode
- retired  out  CNT_W  retired-instruction count, saturating

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5. Codes 6 and 7 go to IDLE on the next edge.
- IDLE: go to FETCH if run=1. In step mode, also require step_req=1.
- FETCH: ir_we=1. Go to DECODE.
- DECODE: capture target=inst[4:0] and the opcode class.
  - Opcode 7 (HALT) goes to HALT.
  - Otherwise go to EXEC.
- EXEC, ALU ops (opcodes 0–5): latch alu_zero into the internal zero flag, then go to WB.
- EXEC, opcode 6 (BZ):
  - Assert pc_we=1, with pc_sel = zero flag (flag value from before this instruction).
  - Flag unchanged. Retire. Go to FETCH (IDLE in step mode).
- WB (ALU ops only): reg_we=1, pc_we=1, pc_sel=0. Retire. Go to FETCH (IDLE in step mode).
- Writes to rd=R0 still assert reg_we; the register file discards them.
- HALT: halted=1 and all enables 0. Go to IDLE when run=0. PC is not advanced past the HALT instruction.
- run=0 is sampled only at instruction boundaries (the retire edge, and in IDLE). An in-flight instruction always completes.
- retired: +1 on every retire edge. Saturates at all-ones; no wrap.
- PC is 8 bits and PC+1 wraps 0xFF→0x00 in the datapath. A branch target reaches PC 0x00–0x1F only.
- Enables are combinational decodes of state (Moore). No output depends combinationally on run, step_req or alu_zero, except pc_sel in EXEC, which uses the registered flag.

## Timing
- Reset values:
  - state=IDLE, all enables 0, pc_sel=0, target=0.
  - halted=0, step_ack=0, retired=0, zero flag=0.
- Reset mid-instruction aborts immediately. No partial write occurs after the edge that follows reset release.
- With run=1 and run held:
  - ALU instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - BZ: 3 cycles.
  - HALT: reaches HALT 2 cycles after FETCH.
- First FETCH occurs 1 cycle after run is seen high in IDLE.
- Back-to-back instructions: the cycle after WB/EXEC-retire is FETCH. No bubbles.
- step_ack is high during the single cycle after the retire edge, coincident with IDLE.

## Configuration
- CPU_CTRL_STEP_EN defined: step_mode, step_req and step_ack are active.
  - With step_mode=1, each instruction needs step_req high in IDLE and returns to IDLE on retire with a step_ack pulse.
  - step_req held high executes one instruction per IDLE visit, i.e. one extra cycle per instruction.
  - step_mode changes take effect at the next IDLE/retire decision.
- Not defined: the ports remain; step_mode and step_req are ignored and step_ack is tied 0. Retire goes straight to FETCH.

## Test plan
- RST pulse mid-EXEC with reg_we pending → state=0, enables 0, retired=0 immediately; no reg_we after release.
- run=1, inst=0x25 (opcode 1) → ir_we at cycle 1, reg_we and pc_we at cycle 4 with pc_sel=0, retired=1; FETCH again at cycle 5.
- ALU op with alu_zero=1, then inst=0xD4 (BZ, target 0x14) → pc_we with pc_sel=1 and target=0x14 in EXEC, retired=2. Repeat with alu_zero=0 → pc_sel=0.
- inst=0xE0 (HALT) → halted=1 two cycles after FETCH, no enables, retired unchanged. run=0 → IDLE next cycle.
- Preload retired at 0xFFFE, execute 3 ALU ops → retired ends at 0xFFFF.
- With CPU_CTRL_STEP_EN, step_mode=1, one step_req pulse → exactly one instruction retires, then step_ack=1 for one cycle, and the sequencer waits in IDLE.
